// File: rtl/seq_detector_pkg.sv
// Shared types, widths and helpers for the scheduled sequence detector.
package seq_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MATCH_TOTAL_W = 16;

    // Ceiling log2, used to size requester indices.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: walks a latched pattern one bit per step and
// flags the step that completes the whole pattern.
module seq_match_core
    import seq_detector_pkg::*;
#(
    parameter int unsigned STATE_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          step,
    input  logic                          x,
    input  logic [(1<<STATE_BITS)-1:0]    pattern,
    output logic                          full_match
);

    localparam int unsigned SEQ_LEN = 1 << STATE_BITS;

    logic [SEQ_LEN-1:0]    r_pattern;
    logic [STATE_BITS-1:0] r_state;
    logic                  w_bit_eq;
    logic                  w_last;

    assign w_bit_eq   = (x == r_pattern[r_state]);
    assign w_last     = (r_state == STATE_BITS'(SEQ_LEN - 1));
    assign full_match = step && w_bit_eq && w_last;

    // Pattern latch and match progress; a mismatching bit is consumed and
    // restarts the walk without being compared against the first pattern bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= '0;
            r_state   <= '0;
        end else if (clear) begin
            r_pattern <= pattern;
            r_state   <= '0;
        end else if (step) begin
            if (w_bit_eq) begin
                r_state <= r_state + STATE_BITS'(1);
            end else begin
                r_state <= '0;
            end
        end
    end

endmodule

// File: rtl/seq_detector_sched.sv
// Round-robin scheduler that time-shares one serial sequence matcher among
// several requesters and reports each transaction with a one-cycle done pulse.
module seq_detector_sched
    import seq_detector_pkg::*;
#(
    parameter int unsigned STATE_BITS = 3,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BUDGET_W   = 8
) (
    input  logic                                clock0,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*(1<<STATE_BITS)-1:0]  req_pattern,
    input  logic [NUM_REQ*BUDGET_W-1:0]         req_budget,
    input  logic                                bit_valid,
    input  logic                                bit_data,
    output logic                                bit_ready,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                busy,
    output logic                                done,
    output logic [clog2(NUM_REQ)-1:0]           done_id,
    output logic                                done_hit,
    output logic [BUDGET_W-1:0]                 done_count,
    output logic [MATCH_TOTAL_W-1:0]            match_total
);

    localparam int unsigned SEQ_LEN = 1 << STATE_BITS;
    localparam int unsigned ID_W    = clog2(NUM_REQ);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [NUM_REQ-1:0]       r_gnt;
    logic [NUM_REQ-1:0]       w_gnt_nxt;
    logic                     r_busy;
    logic                     w_busy_nxt;
    logic                     r_bit_ready;
    logic                     w_bit_ready_nxt;
    logic [ID_W-1:0]          r_ptr;
    logic [ID_W-1:0]          w_ptr_nxt;
    logic [ID_W-1:0]          r_id;
    logic [ID_W-1:0]          w_id_nxt;
    logic [BUDGET_W-1:0]      r_budget;
    logic [BUDGET_W-1:0]      w_budget_nxt;
    logic [BUDGET_W-1:0]      r_count;
    logic [BUDGET_W-1:0]      w_count_nxt;
    logic                     r_done;
    logic                     w_done_nxt;
    logic [ID_W-1:0]          r_done_id;
    logic [ID_W-1:0]          w_done_id_nxt;
    logic                     r_done_hit;
    logic                     w_done_hit_nxt;
    logic [BUDGET_W-1:0]      r_done_count;
    logic [BUDGET_W-1:0]      w_done_count_nxt;
    logic [MATCH_TOTAL_W-1:0] r_match_total;
    logic [MATCH_TOTAL_W-1:0] w_match_total_nxt;

    logic                     w_arb_found;
    logic [ID_W-1:0]          w_arb_id;
    logic [SEQ_LEN-1:0]       w_arb_pattern;
    logic [BUDGET_W-1:0]      w_arb_budget;
    logic [ID_W-1:0]          w_id_inc;
    logic [BUDGET_W-1:0]      w_count_inc;
    logic                     w_accept;
    logic                     w_clear;
    logic                     w_step;
    logic                     w_full_match;

    // Round-robin pick: first requesting index at or above the pointer, wrapping.
    always_comb begin
        logic [ID_W:0] v_idx;
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        v_idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
            if (v_idx >= (ID_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_arb_found && req[v_idx[ID_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_id    = v_idx[ID_W-1:0];
            end
        end
    end

    assign w_arb_pattern = req_pattern[int'(w_arb_id)*SEQ_LEN +: SEQ_LEN];
    assign w_arb_budget  = req_budget[int'(w_arb_id)*BUDGET_W +: BUDGET_W];
    assign w_id_inc      = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
    assign w_count_inc   = r_count + BUDGET_W'(1);
    assign w_accept      = r_bit_ready && bit_valid && req[r_id];

    seq_match_core #(
        .STATE_BITS (STATE_BITS)
    ) u_core (
        .clk        (clock0),
        .rst_n      (reset),
        .clear      (w_clear),
        .step       (w_step),
        .x          (bit_data),
        .pattern    (w_arb_pattern),
        .full_match (w_full_match)
    );

    // Next-state and registered-output decode for the grant/run/done FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_bit_ready_nxt   = r_bit_ready;
        w_ptr_nxt         = r_ptr;
        w_id_nxt          = r_id;
        w_budget_nxt      = r_budget;
        w_count_nxt       = r_count;
        w_done_nxt        = 1'b0;
        w_done_id_nxt     = '0;
        w_done_hit_nxt    = 1'b0;
        w_done_count_nxt  = '0;
        w_match_total_nxt = r_match_total;
        w_clear           = 1'b0;
        w_step            = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    w_clear         = 1'b1;
                    w_gnt_nxt       = NUM_REQ'(1) << w_arb_id;
                    w_id_nxt        = w_arb_id;
                    w_budget_nxt    = w_arb_budget;
                    w_count_nxt     = '0;
                    w_bit_ready_nxt = (w_arb_budget != '0);
                    w_state_nxt     = RUN;
                end
            end
            RUN: begin
                if (!req[r_id]) begin
                    // Requester withdrew: release silently, any bit this cycle is dropped.
                    w_gnt_nxt       = '0;
                    w_bit_ready_nxt = 1'b0;
                    w_ptr_nxt       = w_id_inc;
                    w_state_nxt     = IDLE;
                end else if (r_budget == '0) begin
                    w_gnt_nxt       = '0;
                    w_bit_ready_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_done_id_nxt   = r_id;
                    w_state_nxt     = DONE;
                end else if (w_accept) begin
                    w_step      = 1'b1;
                    w_count_nxt = w_count_inc;
                    if (w_full_match || (w_count_inc == r_budget)) begin
                        w_gnt_nxt        = '0;
                        w_bit_ready_nxt  = 1'b0;
                        w_done_nxt       = 1'b1;
                        w_done_id_nxt    = r_id;
                        w_done_hit_nxt   = w_full_match;
                        w_done_count_nxt = w_count_inc;
                        w_state_nxt      = DONE;
                    end
                end
            end
            DONE: begin
                w_ptr_nxt   = w_id_inc;
                w_state_nxt = IDLE;
                if (r_done_hit && (r_match_total != {MATCH_TOTAL_W{1'b1}})) begin
                    w_match_total_nxt = r_match_total + MATCH_TOTAL_W'(1);
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_bit_ready_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase

        w_busy_nxt = |w_gnt_nxt;
    end

    // State and output registers.
    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_busy        <= 1'b0;
            r_bit_ready   <= 1'b0;
            r_ptr         <= '0;
            r_id          <= '0;
            r_budget      <= '0;
            r_count       <= '0;
            r_done        <= 1'b0;
            r_done_id     <= '0;
            r_done_hit    <= 1'b0;
            r_done_count  <= '0;
            r_match_total <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_busy        <= w_busy_nxt;
            r_bit_ready   <= w_bit_ready_nxt;
            r_ptr         <= w_ptr_nxt;
            r_id          <= w_id_nxt;
            r_budget      <= w_budget_nxt;
            r_count       <= w_count_nxt;
            r_done        <= w_done_nxt;
            r_done_id     <= w_done_id_nxt;
            r_done_hit    <= w_done_hit_nxt;
            r_done_count  <= w_done_count_nxt;
            r_match_total <= w_match_total_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign bit_ready   = r_bit_ready;
    assign done        = r_done;
    assign done_id     = r_done_id;
    assign done_hit    = r_done_hit;
    assign done_count  = r_done_count;
    assign match_total = r_match_total;

endmodule

// File: doc/seq_detector_sched.md
Name: seq_detector_sched

Overview:
- Time-shares one serial sequence-match core among NUM_REQ requesters, arbitrated round-robin.
- The granted requester's pattern and bit budget are latched, and its bit stream is scanned until a full pattern match or budget exhaustion.
- The result is returned as a one-cycle done pulse.
- Sits between host-side requesters and the FSM sequence-detection datapath in the fsm micro-benchmark set.

Parameters:
- STATE_BITS, 3, core state width; pattern length SEQ_LEN = 2**STATE_BITS.
- NUM_REQ, 4, number of requesters (2..16); ID_W = clog2(NUM_REQ).
- BUDGET_W, 8, width of per-request bit budget and consumed-bit count.

Ports:
- clock0  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NUM_REQ  per-requester request level.
- req_pattern  in  NUM_REQ*SEQ_LEN  requester i pattern in slice [i*SEQ_LEN +: SEQ_LEN]; bit 0 is expected first.
- req_budget  in  NUM_REQ*BUDGET_W  requester i maximum bits to scan.
- bit_valid  in  1  shared stream valid; driven by the granted requester.
- bit_data  in  1  stream bit.
- bit_ready  out  1  high in RUN; a bit is accepted when bit_valid & bit_ready.
- gnt  out  NUM_REQ  one-hot grant, registered.
- busy  out  1  high while any grant is held.
- done  out  1  one-cycle result pulse.
- done_id  out  ID_W  requester index of the result.
- done_hit  out  1  1 = full pattern matched.
- done_count  out  BUDGET_W  bits accepted in the transaction, including the final bit.
- match_total  out  16  saturating count of hits since reset.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; all outputs 0; rr pointer=0; core state=0; match_total=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, no req: remain in IDLE.
- IDLE, any req bit set:
  - Select the first set bit searching upward from the rr pointer, wrapping.
  - Next edge: set gnt[id]; latch id, pattern and budget; clear core state and count.
  - If the latched budget = 0: go to DONE with hit=0, count=0.
  - Otherwise go to RUN. bit_ready is high the cycle after the req sample (1-cycle arbitration latency).
- RUN, per accepted bit x, with core state s in 0..SEQ_LEN-1:
  - x == pattern[s] and s == SEQ_LEN-1: full match; go to DONE with hit=1.
  - x == pattern[s] and s < SEQ_LEN-1: s <= s+1.
  - x != pattern[s]: s <= 0; the bit is consumed and is not re-compared against pattern[0].
  - count <= count+1 on every accepted bit.
  - If no match and count+1 == budget: go to DONE with hit=0.
  - When match and budget exhaustion coincide, the match wins (hit=1).
- RUN, req[id] deasserted: abort.
  - Next edge: gnt=0, bit_ready=0, no done pulse.
  - rr pointer <= id+1 mod NUM_REQ; go to IDLE.
  - A bit accepted in the same cycle is discarded.
- DONE (exactly 1 cycle):
  - done=1, with done_id, done_hit, done_count valid only in this cycle; gnt and bit_ready are 0.
  - rr pointer <= id+1 mod NUM_REQ.
  - match_total increments on hit and saturates at 0xFFFF.
  - Next state is IDLE; the earliest new gnt is 2 cycles after done.
- done is asserted the cycle after the final accepted bit.
- A requester that keeps req high is re-arbitrated fairly behind the others.
- Pattern and budget inputs are sampled only at grant; later changes are ignored.
- busy = |gnt.
- All outputs are registered; no combinational path from input to output except bit_ready, which is decoded from FSM state only.

Decomposition:
- Package seq_detector_pkg holds:
  - FSM state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - MATCH_TOTAL_W=16.
  - Function clog2.
- One sub-module, seq_match_core: holds pattern, state register and match/step logic. Inputs: clear, step, x, pattern. Output: full_match.
- Arbiter and FSM stay in seq_detector_sched.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, no req -> outputs stay 0 for 10 cycles.
- Hit (STATE_BITS=3, NUM_REQ=4):
  - req[0]=1, pattern=8'b1011_0010, budget=20; stream 0,1,0,0,1,1,0,1 with valid held high.
  - Required: gnt=4'b0001 one cycle after req; done one cycle after the 8th bit with done_id=0, hit=1, count=8; match_total=1.
- Mismatch restart: same pattern; stream 0,1,1 then the 8 pattern bits -> hit=1, count=11. The mismatching third bit is consumed with no re-compare.
- Budget exhaustion: pattern=8'hFF, budget=5, stream five 0s -> done with hit=0, count=5, match_total unchanged. Separately, budget=0 -> done two cycles after req with count=0, no bit_ready.
- Round-robin: req=4'b1101 held, each transaction finishing with budget=1 -> grant order 0,2,3,0.
- Abort/reset:
  - Drop req[2] mid-RUN -> gnt clears next edge, no done pulse, next grant goes to requester 3.
  - Assert reset mid-RUN asynchronously -> outputs 0 immediately; match_total=0.
